ins_fetch_ctrl: RTL and testbench

- Instruction fetch sequencer for the 16x8 instruction memory.
- Owns the program counter and drives the memory read address; the memory read is combinational.
- Captures fetched words into a small prefetch buffer and hands them to the decoder over a valid/ready handshake.
- Supports redirect (branch/jump) with buffer flush, and stops fetching on a halt opcode.

---
 rtl/ins_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_ins_fetch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_ctrl.sv
// rtl/ins_fetch_ctrl.sv - instruction fetch sequencer with prefetch buffer, redirect and halt
module ins_fetch_ctrl #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] HALT_OP = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head, tail;
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic [DATA_W-1:0] last_data;
  logic [ADDR_W-1:0] last_pc;
  logic              pop, push;

  assign mem_addr  = pc;
  assign ins_valid = (count != '0);
  assign halted    = (state == S_HALT);
  assign pop       = ins_valid && ins_ready;
  assign push      = (state == S_FETCH) && run && !redirect_valid &&
                     ((count < CNT_W'(DEPTH)) || pop);

  // An empty buffer keeps showing whatever was presented on the previous cycle.
  assign ins_data = ins_valid ? buf_data[head] : last_data;
  assign ins_pc   = ins_valid ? buf_pc[head]   : last_pc;

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run) state_nxt = S_FETCH;
        S_FETCH: begin
          if (!run)
            state_nxt = S_IDLE;
          else if (push && (mem_data == HALT_OP))
            state_nxt = S_HALT;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      last_data <= '0;
      last_pc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      last_data <= ins_data;
      last_pc   <= ins_pc;
      if (redirect_valid) begin
        // Flush wins over any pop on this edge; the popped word was already taken.
        pc    <= redirect_addr;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          buf_data[tail] <= mem_data;
          buf_pc[tail]   <= pc;
          tail           <= tail + 1'b1;
          pc             <= pc + 1'b1;
        end
        if (pop)
          head <= head + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// tb/tb_ins_fetch_ctrl.sv - randomized and directed bench for ins_fetch_ctrl against a queue model
module tb_ins_fetch_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready;
  logic              halted;

  logic [DATA_W-1:0] mem [16];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  ins_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HALT_OP(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .halted         (halted)
  );

  int errors = 0;
  int checks = 0;

  // Reference: mode 0 idle, 1 fetching, 2 halted; queue entries are {data, pc}.
  int          m_pc;
  int          m_mode;
  logic [11:0] q [$];
  logic [7:0]  hold_data;
  logic [3:0]  hold_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc      = 0;
    m_mode    = 0;
    hold_data = '0;
    hold_pc   = '0;
  endtask

  task automatic model_step();
    bit pop, push;
    pop = (q.size() > 0) && ins_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc   = int'(redirect_addr);
      m_mode = run ? 1 : 0;
    end else begin
      push = (m_mode == 1) && run && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (m_mode == 0 && run) m_mode = 1;
      else if (m_mode == 1 && !run) m_mode = 0;
      if (push) begin
        q.push_back({mem[m_pc], 4'(m_pc)});
        if (mem[m_pc] == 8'h00) m_mode = 2;
        m_pc = (m_pc + 1) % 16;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] ed;
    logic [3:0] ep;
    bit         ev;
    ev = (q.size() > 0);
    if (ev) {ed, ep} = q[0];
    else begin
      ed = hold_data;
      ep = hold_pc;
    end
    check("ins_valid", ins_valid, ev);
    check("ins_data", ins_data, ed);
    check("ins_pc", ins_pc, ep);
    check("mem_addr", mem_addr, m_pc);
    check("halted", halted, m_mode == 2);
    hold_data = ed;
    hold_pc   = ep;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_in(input logic r, input logic rdy, input logic rv, input logic [3:0] ra);
    run            = r;
    ins_ready      = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    model_reset();
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    mem[0] = 8'h85; mem[1] = 8'h26; mem[2] = 8'hD0; mem[3] = 8'hD7;
    for (int i = 4; i < 16; i++) mem[i] = 8'h40 | 8'(i);

    // stream: first word two edges after run rises, then one per cycle
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (6) step();

    // backpressure then release
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (4) step();
    ins_ready = 1'b1;
    repeat (5) step();

    // async reset while the buffer is full
    ins_ready = 1'b0;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1 reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (4) step();

    // address wrap 14,15,0,1
    set_in(1'b1, 1'b1, 1'b1, 4'd14);
    step();
    redirect_valid = 1'b0;
    repeat (6) step();

    // redirect while full and popping on the same edge
    set_in(1'b1, 1'b0, 1'b1, 4'd3);
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    set_in(1'b1, 1'b1, 1'b1, 4'd9);
    step();
    redirect_valid = 1'b0;
    repeat (3) step();

    // halt at address 5, then resume via redirect
    mem[5] = 8'h00;
    set_in(1'b1, 1'b1, 1'b1, 4'd0);
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    check("halt_reached", halted, 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 4'd0);
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    mem[5] = 8'h45;

    // randomized traffic with occasional halt opcodes
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int n = 0; n < 500; n++) begin
      run            = ($urandom_range(0, 7) != 0);
      ins_ready      = 1'($urandom_range(0, 1));
      redirect_valid = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      redirect_addr  = 4'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
